decode_queue: RTL and testbench



---
 rtl/decode_queue.sv | 201 ++++++++++++++++++++
 tb/tb_decode_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: RV32I/RV64I decoder feeding a DEPTH-entry queue of decoded instructions.
// Define ID_MEXT_EN to add M-extension decode; the default build treats funct7=0000001 as illegal.
module decode_queue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_op,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic            out_ill
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("decode_queue: XLEN must be 32 or 64");
   end

   localparam bit Is64 = (XLEN == 64);
`ifdef ID_MEXT_EN
   localparam bit MExt = 1'b1;
`else
   localparam bit MExt = 1'b0;
`endif
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = 2 * XLEN + 28;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpImm32  = 7'b0011011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpReg32  = 7'b0111011;

   logic [6:0]      w_opc;
   logic [6:0]      w_f7;
   logic [2:0]      w_f3;
   logic            w_sh_zero;
   logic            w_sh_sra;
   logic            w_f7_alu;
   logic            w_f3_alt;
   logic [31:0]     w_imm_i;
   logic [31:0]     w_imm_s;
   logic [31:0]     w_imm_b;
   logic [31:0]     w_imm_j;
   logic            w_ill;
   logic            w_m;
   logic            w_alt;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;

   assign w_opc = in_instr[6:0];
   assign w_f3  = in_instr[14:12];
   assign w_f7  = in_instr[31:25];
   // RV64 shift amounts are 6 bits wide, so only instr[31:26] are function bits.
   assign w_sh_zero = Is64 ? (in_instr[31:26] == 6'b000000) : (w_f7 == 7'b0000000);
   assign w_sh_sra  = Is64 ? (in_instr[31:26] == 6'b010000) : (w_f7 == 7'b0100000);
   assign w_f7_alu  = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
   assign w_f3_alt  = (w_f3 == 3'b000) || (w_f3 == 3'b101);

   assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign w_imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign w_imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      w_ill   = 1'b0;
      w_m     = 1'b0;
      w_alt   = 1'b0;
      w_rs1   = in_instr[19:15];
      w_rs2   = 5'd0;
      w_rd    = in_instr[11:7];
      w_imm32 = 32'd0;
      case (w_opc)
         OpLui, OpAuipc: begin
            w_rs1   = 5'd0;
            w_imm32 = {in_instr[31:12], 12'h000};
         end
         OpJal: begin
            w_rs1   = 5'd0;
            w_imm32 = w_imm_j;
         end
         OpJalr: begin
            w_imm32 = w_imm_i;
            w_ill   = (w_f3 != 3'b000);
         end
         OpBranch: begin
            w_imm32 = w_imm_b;
            w_rs2   = in_instr[24:20];
            w_rd    = 5'd0;
            w_ill   = (w_f3[2:1] == 2'b01);
         end
         OpLoad: begin
            w_imm32 = w_imm_i;
            w_ill   = Is64 ? (w_f3 == 3'b111) : ((w_f3 == 3'b011) || (w_f3[2:1] == 2'b11));
         end
         OpStore: begin
            w_imm32 = w_imm_s;
            w_rs2   = in_instr[24:20];
            w_rd    = 5'd0;
            w_ill   = Is64 ? (w_f3 > 3'b011) : (w_f3 > 3'b010);
         end
         OpImm: begin
            w_imm32 = w_imm_i;
            if (w_f3 == 3'b101) w_alt = in_instr[30];
            if (w_f3 == 3'b001) w_ill = !w_sh_zero;
            else if (w_f3 == 3'b101) w_ill = !(w_sh_zero || w_sh_sra);
         end
         OpImm32: begin
            w_imm32 = w_imm_i;
            if (w_f3 == 3'b101) w_alt = in_instr[30];
            case (w_f3)
               3'b000:  w_ill = !Is64;
               3'b001:  w_ill = !Is64 || (w_f7 != 7'b0000000);
               3'b101:  w_ill = !Is64 || !w_f7_alu;
               default: w_ill = 1'b1;
            endcase
         end
         OpReg: begin
            w_rs2 = in_instr[24:20];
            if (w_f3_alt) w_alt = in_instr[30];
            if (MExt && w_f7 == 7'b0000001) w_m = 1'b1;
            else if (w_f3_alt) w_ill = !w_f7_alu;
            else w_ill = (w_f7 != 7'b0000000);
         end
         OpReg32: begin
            w_rs2 = in_instr[24:20];
            if (w_f3_alt) w_alt = in_instr[30];
            if (!Is64) w_ill = 1'b1;
            else if (MExt && w_f7 == 7'b0000001 && (w_f3 == 3'b000 || w_f3[2])) w_m = 1'b1;
            else if (w_f3_alt) w_ill = !w_f7_alu;
            else if (w_f3 == 3'b001) w_ill = (w_f7 != 7'b0000000);
            else w_ill = 1'b1;
         end
         default: w_ill = 1'b1;
      endcase
   end

   assign w_imm = XLEN'($signed(w_imm32));

   logic [EW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_head;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = (r_count < CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= next_ptr(r_tail);
         if (w_pop) r_head <= next_ptr(r_head);
         if (w_push && !w_pop) r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && reset_n) begin
         r_mem[r_tail] <= {in_pc, w_opc, w_m, w_alt, w_f3, w_rs1, w_rs2, w_rd, w_imm, w_ill};
      end
   end

   // Data outputs read as zero whenever the queue is empty.
   assign w_head = out_valid ? r_mem[r_head] : '0;
   assign {out_pc, out_opcode, out_op, out_rs1, out_rs2, out_rd, out_imm, out_ill} = w_head;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: drives an RV32 and an RV64 decode_queue (DEPTH=2) with the same stimulus and
// compares both against a queue-based reference decoder.
module tb_decode_queue;

   localparam int Depth = 2;

   typedef struct packed {
      logic [6:0]  opc;
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] imm;
      logic        ill;
   } dec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        in_ready_32, out_valid_32, out_ill_32;
   logic [31:0] out_pc_32, out_imm_32;
   logic [6:0]  out_opcode_32;
   logic [4:0]  out_op_32, out_rs1_32, out_rs2_32, out_rd_32;
   logic        in_ready_64, out_valid_64, out_ill_64;
   logic [63:0] out_pc_64, out_imm_64;
   logic [6:0]  out_opcode_64;
   logic [4:0]  out_op_64, out_rs1_64, out_rs2_64, out_rd_64;

   int checks = 0;
   int failures = 0;
   logic [95:0] q[$];
   logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B,
                             7'h33, 7'h3B};

   always #5 clk = ~clk;

   decode_queue #(.XLEN(32), .DEPTH(Depth)) u_dut32 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
      .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid_32), .out_ready(out_ready),
      .out_pc(out_pc_32), .out_opcode(out_opcode_32), .out_op(out_op_32), .out_rs1(out_rs1_32),
      .out_rs2(out_rs2_32), .out_rd(out_rd_32), .out_imm(out_imm_32), .out_ill(out_ill_32)
   );

   decode_queue #(.XLEN(64), .DEPTH(Depth)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_64), .out_ready(out_ready),
      .out_pc(out_pc_64), .out_opcode(out_opcode_64), .out_op(out_op_64), .out_rs1(out_rs1_64),
      .out_rs2(out_rs2_64), .out_rd(out_rd_64), .out_imm(out_imm_64), .out_ill(out_ill_64)
   );

   function automatic dec_t ref_decode(input logic [31:0] ins, input bit rv64);
      dec_t d;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [6:0] hi;
      longint imm_i, imm_s, imm_b, imm_j, imm_u;
      bit mext;
`ifdef ID_MEXT_EN
      mext = 1'b1;
`else
      mext = 1'b0;
`endif
      f3 = ins[14:12];
      f7 = ins[31:25];
      hi = rv64 ? {ins[31:26], 1'b0} : f7;
      imm_i = $signed(ins[31:20]);
      imm_s = $signed({ins[31:25], ins[11:7]});
      imm_b = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      imm_j = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      imm_u = $signed({ins[31:12], 12'h000});
      d = '0;
      d.opc = ins[6:0];
      d.op[2:0] = f3;
      d.rs1 = ins[19:15];
      d.rd = ins[11:7];
      case (ins[6:0])
         7'h37, 7'h17: begin d.rs1 = 5'd0; d.imm = imm_u; end
         7'h6F: begin d.rs1 = 5'd0; d.imm = imm_j; end
         7'h67: begin d.imm = imm_i; d.ill = (f3 != 3'd0); end
         7'h63: begin
            d.imm = imm_b; d.rd = 5'd0; d.rs2 = ins[24:20];
            d.ill = f3 inside {3'd2, 3'd3};
         end
         7'h03: begin
            d.imm = imm_i;
            d.ill = rv64 ? (f3 == 3'd7) : (f3 inside {3'd3, 3'd6, 3'd7});
         end
         7'h23: begin
            d.imm = imm_s; d.rd = 5'd0; d.rs2 = ins[24:20];
            d.ill = rv64 ? (f3 > 3'd3) : (f3 > 3'd2);
         end
         7'h13: begin
            d.imm = imm_i;
            if (f3 == 3'd5) d.op[3] = ins[30];
            if (f3 == 3'd1) d.ill = (hi != 7'h00);
            else if (f3 == 3'd5) d.ill = !(hi inside {7'h00, 7'h20});
         end
         7'h1B: begin
            d.imm = imm_i;
            if (f3 == 3'd5) d.op[3] = ins[30];
            d.ill = !rv64 || !((f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'h00) ||
                               (f3 == 3'd5 && f7 inside {7'h00, 7'h20}));
         end
         7'h33: begin
            d.rs2 = ins[24:20];
            if (f3 inside {3'd0, 3'd5}) d.op[3] = ins[30];
            if (f7 == 7'h01) begin
               d.ill = !mext; d.op[4] = mext;
            end else begin
               d.ill = !((f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
            end
         end
         7'h3B: begin
            d.rs2 = ins[24:20];
            if (f3 inside {3'd0, 3'd5}) d.op[3] = ins[30];
            if (!rv64) begin
               d.ill = 1'b1;
            end else if (f7 == 7'h01) begin
               d.op[4] = mext && !(f3 inside {3'd1, 3'd2, 3'd3});
               d.ill = !d.op[4];
            end else begin
               d.ill = !((f3 inside {3'd0, 3'd5} && f7 inside {7'h00, 7'h20}) ||
                         (f3 == 3'd1 && f7 == 7'h00));
            end
         end
         default: d.ill = 1'b1;
      endcase
      return d;
   endfunction

   function automatic logic [255:0] exp_vec(input bit rv64);
      logic [255:0] v;
      dec_t d;
      logic [63:0] pc, imm;
      v = '0;
      v[0] = (q.size() < Depth);
      if (q.size() != 0) begin
         d = ref_decode(q[0][95:64], rv64);
         pc = q[0][63:0];
         imm = d.imm;
         if (!rv64) begin pc[63:32] = '0; imm[63:32] = '0; end
         v[1] = 1'b1; v[2 +: 64] = pc; v[66 +: 7] = d.opc; v[73 +: 5] = d.op;
         v[78 +: 5] = d.rs1; v[83 +: 5] = d.rs2; v[88 +: 5] = d.rd; v[93 +: 64] = imm;
         v[157] = d.ill;
      end
      return v;
   endfunction

   function automatic logic [255:0] obs32();
      logic [255:0] v;
      v = '0;
      v[0] = in_ready_32; v[1] = out_valid_32; v[2 +: 32] = out_pc_32;
      v[66 +: 7] = out_opcode_32; v[73 +: 5] = out_op_32; v[78 +: 5] = out_rs1_32;
      v[83 +: 5] = out_rs2_32; v[88 +: 5] = out_rd_32; v[93 +: 32] = out_imm_32;
      v[157] = out_ill_32;
      return v;
   endfunction

   function automatic logic [255:0] obs64();
      logic [255:0] v;
      v = '0;
      v[0] = in_ready_64; v[1] = out_valid_64; v[2 +: 64] = out_pc_64;
      v[66 +: 7] = out_opcode_64; v[73 +: 5] = out_op_64; v[78 +: 5] = out_rs1_64;
      v[83 +: 5] = out_rs2_64; v[88 +: 5] = out_rd_64; v[93 +: 64] = out_imm_64;
      v[157] = out_ill_64;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, advance the reference queue, then compare both DUTs.
   task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
      bit push, pop;
      in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
      in_pc = {$urandom(), $urandom()};
      push = v && !fl && (q.size() < Depth);
      pop = rdy && !fl && (q.size() != 0);
      @(posedge clk);
      if (!reset_n || fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back({ins, in_pc});
      end
      #1;
      chk("rv32_outputs", obs32(), exp_vec(1'b0));
      chk("rv64_outputs", obs64(), exp_vec(1'b1));
   endtask

   initial begin
      logic [31:0] ins;
      reset_n = 1'b0;
      step(1'b1, 32'h00500093, 1'b1, 1'b0);
      chk("reset_ready", 256'(in_ready_32), 256'(1));
      chk("reset_valid", 256'(out_valid_64), 256'(0));
      reset_n = 1'b1;

      // addi x1,x0,5 appears one cycle after the push
      step(1'b1, 32'h00500093, 1'b0, 1'b0);
      chk("addi_rd", 256'(out_rd_32), 256'(1));
      chk("addi_imm", 256'(out_imm_32), 256'(5));
      chk("addi_op", 256'({out_op_32, out_rs1_32, out_rs2_32, out_ill_32}), 256'(0));
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Backpressure: third push held off until a slot frees
      step(1'b1, 32'h00500093, 1'b0, 1'b0);
      step(1'b1, 32'hFFF00113, 1'b0, 1'b0);
      chk("full_ready", 256'({in_ready_32, in_ready_64}), 256'(0));
      step(1'b1, 32'h800000B7, 1'b0, 1'b0);
      step(1'b1, 32'h800000B7, 1'b1, 1'b0);
      chk("neg1_rd", 256'(out_rd_64), 256'(2));
      chk("neg1_imm64", 256'(out_imm_64), 256'(64'hFFFF_FFFF_FFFF_FFFF));
      step(1'b1, 32'h800000B7, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("lui_imm64", 256'(out_imm_64), 256'(64'hFFFF_FFFF_8000_0000));
      chk("lui_imm32", 256'(out_imm_32), 256'(32'h8000_0000));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drained", 256'({out_valid_32, out_pc_64, out_imm_64}), 256'(0));

      // Flush with a concurrent push while two entries are queued
      step(1'b1, 32'h00500093, 1'b0, 1'b0);
      step(1'b1, 32'h00500093, 1'b0, 1'b0);
      step(1'b1, 32'h800000B7, 1'b0, 1'b1);
      chk("flush_state", 256'({out_valid_64, in_ready_64}), 256'(1));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("flush_push_dropped", 256'(out_valid_32), 256'(0));

      // M extension, unknown opcode, addw
      step(1'b1, 32'h02208033, 1'b0, 1'b0);
`ifdef ID_MEXT_EN
      chk("mul_mext", 256'({out_ill_32, out_op_32}), 256'(6'b010000));
`else
      chk("mul_nomext", 256'({out_ill_64, out_op_64}), 256'(6'b100000));
`endif
      step(1'b1, 32'h0000705B, 1'b1, 1'b0);
      chk("bad_opcode", 256'({out_ill_32, out_ill_64}), 256'(3));
      step(1'b1, 32'h0000003B, 1'b1, 1'b0);
      chk("addw_ill", 256'({out_ill_32, out_ill_64}), 256'(2));
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Reset mid-stream discards entries
      step(1'b1, 32'h00500093, 1'b0, 1'b0);
      reset_n = 1'b0;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("reset_mid", 256'({out_valid_32, out_valid_64}), 256'(0));
      reset_n = 1'b1;

      for (int i = 0; i < 500; i++) begin
         ins = $urandom();
         if ($urandom_range(3) != 0) begin
            ins[6:0] = opcs[$urandom_range(10)];
            case ($urandom_range(3))
               0: ins[31:25] = 7'h00;
               1: ins[31:25] = 7'h20;
               2: ins[31:25] = 7'h01;
               default: ;
            endcase
         end
         reset_n = ($urandom_range(99) != 0);
         step($urandom_range(2) != 0, ins, $urandom_range(2) != 0, $urandom_range(29) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
